// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and
// the baud divider constant shared with the baud tick generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS         = 8;
  localparam int TICKS_PER_BIT_DEF = 16;
  localparam int CLK_HZ            = 100_000_000;
  localparam int BAUD_RATE         = 115_200;

  // System clocks per oversample tick for a given baud and oversampling ratio.
  function automatic int baud_tick_div(input int clk_hz, input int baud, input int ticks_per_bit);
    return clk_hz / (baud * ticks_per_bit);
  endfunction

  localparam int BAUD_TICK_DIV = baud_tick_div(CLK_HZ, BAUD_RATE, TICKS_PER_BIT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);

  // Rotate the request vector so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;
    int                   sum;
    dbl   = {req, req} >> ptr;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    gnt   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (enable && !found && dbl[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end else begin
          sum = sum;
        end
        idx = PW'(sum);
      end else begin
        found = found;
      end
    end
    if (found) begin
      gnt = NUM_REQ'(1) << idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler plus 8N1 serializer for the shared UART TX pin.
// Bit timing comes from the 16x oversample strobe b_tick; all outputs are registered.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e            state_r, state_nx;
  logic [TW-1:0]        tick_r, tick_nx;
  logic [2:0]           bit_r, bit_nx;
  logic [7:0]           shift_r, shift_nx;
  logic [PW-1:0]        rr_r, rr_nx;
  logic [PW-1:0]        cur_r, cur_nx;
  logic                 tx_r, tx_nx;
  logic                 busy_r, busy_nx;
  logic                 done_r, done_nx;
  logic [NUM_REQ-1:0]   gnt_r, gnt_nx;

  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [PW-1:0]        arb_idx_s;
  logic [7:0]           sel_byte_s;
  logic                 tick_hit_s;
  logic                 tick_last_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .ptr    (rr_r),
    .enable (state_r == IDLE),
    .gnt    (arb_gnt_s),
    .idx    (arb_idx_s)
  );

  // Mux out the byte of whichever requester the arbiter picked.
  always_comb begin
    sel_byte_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt_s[i]) begin
        sel_byte_s = req_data[8*i +: 8];
      end else begin
        sel_byte_s = sel_byte_s;
      end
    end
  end

  // A b_tick coinciding with the grant pulse is discarded so the start bit gets full length.
  assign tick_hit_s  = b_tick & ~(|gnt_r);
  assign tick_last_s = (tick_r == TICK_LAST);

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_nx = state_r;
    tick_nx  = tick_r;
    bit_nx   = bit_r;
    shift_nx = shift_r;
    rr_nx    = rr_r;
    cur_nx   = cur_r;
    tx_nx    = tx_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    gnt_nx   = '0;
    case (state_r)
      IDLE: begin
        tx_nx = 1'b1;
        if (|arb_gnt_s) begin
          gnt_nx   = arb_gnt_s;
          shift_nx = sel_byte_s;
          cur_nx   = arb_idx_s;
          busy_nx  = 1'b1;
          tick_nx  = '0;
          bit_nx   = 3'd0;
          tx_nx    = 1'b0;
          state_nx = START;
        end else begin
          busy_nx = 1'b0;
        end
      end
      START: begin
        if (tick_hit_s) begin
          if (tick_last_s) begin
            tick_nx  = '0;
            bit_nx   = 3'd0;
            tx_nx    = shift_r[0];
            state_nx = DATA;
          end else begin
            tick_nx = tick_r + TW'(1);
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      DATA: begin
        if (tick_hit_s) begin
          if (tick_last_s) begin
            tick_nx = '0;
            if (bit_r == BIT_LAST) begin
              bit_nx   = 3'd0;
              tx_nx    = 1'b1;
              state_nx = STOP;
            end else begin
              bit_nx   = bit_r + 3'd1;
              shift_nx = {1'b0, shift_r[7:1]};
              tx_nx    = shift_r[1];
            end
          end else begin
            tick_nx = tick_r + TW'(1);
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (tick_hit_s) begin
          if (tick_last_s) begin
            tick_nx  = '0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
            if (cur_r == PW'(NUM_REQ - 1)) begin
              rr_nx = '0;
            end else begin
              rr_nx = cur_r + PW'(1);
            end
          end else begin
            tick_nx = tick_r + TW'(1);
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tick_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      rr_r    <= '0;
      cur_r   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      gnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      tick_r  <= tick_nx;
      bit_r   <= bit_nx;
      shift_r <= shift_nx;
      rr_r    <= rr_nx;
      cur_r   <= cur_nx;
      tx_r    <= tx_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      gnt_r   <= gnt_nx;
    end
  end

  assign gnt  = gnt_r;
  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter. The reference model works
// from the frame definition: count b_ticks after the grant cycle and the line
// must carry {stop, byte, start}[count/16]; done appears on count 160.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_tick;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic        tx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr     = 0;   // model round-robin pointer

  uart_tx_arbiter #(.NUM_REQ(2), .TICKS_PER_BIT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .b_tick   (b_tick),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive b_tick, step past the rising edge, settle.
  task automatic cyc(input bit tk);
    b_tick = tk;
    @(posedge clk);
    #1;
  endtask

  // Round-robin choice: first requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [1:0] r);
    for (int o = 0; o < 2; o++) begin
      if (r[(ptr + o) % 2]) return (ptr + o) % 2;
    end
    return -1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(($urandom_range(0, 1) == 1));
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  // Wait for the expected grant, then follow the whole frame against the model.
  task automatic do_frame(input bit force_gtick, input bit b2b, input logic [1:0] drop_mask,
                          input bit chg_data, input logic [7:0] chg_val, input bit pulse1,
                          input int abort_k, input bit stall);
    int         exp_idx;
    int         k;
    int         cyc_n;
    int         waited;
    bit         got;
    bit         tk;
    logic [7:0] exp_byte;
    logic [9:0] frame;
    exp_idx  = model_pick(req);
    exp_byte = req_data[exp_idx*8 +: 8];
    frame    = {1'b1, exp_byte, 1'b0};
    got      = 1'b0;
    waited   = 0;
    while (!got && waited < 8) begin
      cyc(($urandom_range(0, 1) == 1));
      waited++;
      if (gnt !== 2'b00) got = 1'b1;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    if (b2b) check("back_to_back", 32'(waited), 32'd1);
    check("gnt_onehot", 32'(gnt), 32'(2'b01 << exp_idx));
    check("busy_at_gnt", 32'(busy), 32'd1);
    check("tx_at_gnt", 32'(tx), 32'd0);
    req = req & ~drop_mask;
    if (chg_data) req_data[7:0] = chg_val;
    // b_tick during the grant pulse must not count
    cyc(force_gtick ? 1'b1 : ($urandom_range(0, 1) == 1));
    check("gnt_pulse_len", 32'(gnt), 32'd0);
    check("tx_start", 32'(tx), 32'd0);
    k     = 0;
    cyc_n = 0;
    while (k < 160 && cyc_n < 4000) begin
      if (stall && cyc_n >= 20 && cyc_n < 60) tk = 1'b0;
      else tk = ($urandom_range(0, 1) == 1);
      if (pulse1) req[1] = (cyc_n >= 5 && cyc_n < 8);
      cyc(tk);
      cyc_n++;
      if (tk) k++;
      check("tx", 32'(tx), 32'(frame[(k < 160) ? k / 16 : 9]));
      check("busy", 32'(busy), 32'(k < 160));
      check("done", 32'(done), 32'(k == 160));
      check("gnt_quiet", 32'(gnt), 32'd0);
      if (abort_k > 0 && k == abort_k) return;
    end
    check("frame_len", 32'(k), 32'd160);
    ptr = (exp_idx + 1) % 2;
  endtask

  initial begin
    logic [1:0] r;
    int         p;
    rst      = 1'b1;
    b_tick   = 1'b0;
    req      = 2'b00;
    req_data = 16'h0000;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    cyc(1'b1);
    cyc(1'b0);
    rst = 1'b0;
    idle_check(5);

    // single request, A5, b_tick aligned with the grant pulse
    req_data = 16'h00A5;
    req      = 2'b01;
    do_frame(1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    idle_check(3);

    // contention: both held continuously, frames back to back
    req_data = 16'h3231;
    req      = 2'b11;
    do_frame(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    do_frame(1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    do_frame(1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    req = 2'b00;
    idle_check(4);

    // withdrawal: req[1] pulsed for 3 clks mid-frame must never be granted
    req_data = {8'h77, 8'($urandom_range(0, 255))};
    req      = 2'b01;
    do_frame(1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    idle_check(6);

    // data change after grant: byte sampled at grant only
    req_data = 16'h0055;
    req      = 2'b01;
    do_frame(1'b0, 1'b0, 2'b01, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
    idle_check(2);

    // reset during DATA bit 3: async abort, no done, pointer back to 0
    req_data = 16'h00C3;
    req      = 2'b01;
    do_frame(1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 72, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    cyc(1'b1);
    check("midrst_done_hold", 32'(done), 32'd0);
    cyc(1'b1);
    rst = 1'b0;
    ptr = 0;
    idle_check(2);
    req_data = 16'h9A00;
    req      = 2'b10;
    do_frame(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    idle_check(2);

    // randomized traffic: random request sets and bytes, losers keep holding
    for (int it = 0; it < 6; it++) begin
      req_data = 16'($urandom_range(0, 65535));
      r        = 2'($urandom_range(1, 3));
      req      = req | r;
      p        = model_pick(req);
      do_frame(($urandom_range(0, 1) == 1), 1'b0, 2'(2'b01 << p), 1'b0, 8'h00, 1'b0, 0,
               ($urandom_range(0, 3) == 0));
    end
    while (req != 2'b00) begin
      p = model_pick(req);
      do_frame(1'b0, 1'b0, 2'(2'b01 << p), 1'b0, 8'h00, 1'b0, 0, 1'b0);
    end
    idle_check(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
